// File: rtl/ff_fifo_any_depth_levels.sv
// ---------------------------------------------------------------------------
// ff_fifo_any_depth_levels
//
// Synchronous single-clock FIFO whose depth may be any integer >= 2 (not just
// powers of two). Occupancy is tracked in a dedicated count register, and all
// status flags are decoded from that register alone. The pointers wrap
// explicitly from depth-1 back to 0.
//
// Parameters
//   width              data word width in bits (>= 1)
//   depth              number of storage entries (>= 2)
//   almost_full_level  almost_full  asserts when count >= this (1..depth)
//   almost_empty_level almost_empty asserts when count <= this (0..depth-1)
//
// Ports
//   clk          in   clock, rising-edge active
//   rst          in   asynchronous active-high reset of the control state
//   clr          in   synchronous flush; overrides push/pop in its cycle
//   push         in   write request
//   pop          in   read request
//   write_data   in   word stored on an accepted push
//   read_data    out  head-of-queue word (show-ahead, combinational)
//   empty        out  count == 0
//   full         out  count == depth
//   almost_empty out  count <= almost_empty_level
//   almost_full  out  count >= almost_full_level
//   count        out  current occupancy, 0..depth
//   overflow     out  sticky: a push was rejected
//   underflow    out  sticky: a pop was rejected
//
// Handshake: push and pop are one-cycle requests sampled on the rising edge.
// A pop is accepted whenever the FIFO holds a word. A push is accepted when
// there is room, or when the FIFO is full and a pop in the same cycle frees
// the head entry. Rejected requests are dropped and recorded in the sticky
// overflow/underflow flags; the requester is not stalled.
// ---------------------------------------------------------------------------
module ff_fifo_any_depth_levels #(
    parameter int width              = 8,
    parameter int depth              = 5,
    parameter int almost_full_level  = depth - 1,
    parameter int almost_empty_level = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [width-1:0]           write_data,
    output logic [width-1:0]           read_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    localparam logic [PW-1:0] LAST_IDX = PW'(depth - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(depth);
    localparam logic [CW-1:0] AF_LEVEL = CW'(almost_full_level);
    localparam logic [CW-1:0] AE_LEVEL = CW'(almost_empty_level);

    // Storage has no reset: only the control state below is reset/cleared.
    logic [width-1:0] mem_q [depth];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic empty_w;
    logic full_w;
    logic push_acc;
    logic pop_acc;
    logic write_en;

    // Status decode depends only on the count register, never on the
    // current-cycle requests.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);

    // A pop on a full FIFO always succeeds (depth >= 2 so full implies not
    // empty), which is what lets a simultaneous push enter.
    assign pop_acc  = pop & ~empty_w;
    assign push_acc = push & (~full_w | pop);

    // Flush wins over everything, including the storage write.
    assign write_en = push_acc & ~clr;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push_acc && !pop_acc) begin
                count_d = count_q + CW'(1);
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - CW'(1);
            end
            if (push && !push_acc) begin
                overflow_d = 1'b1;
            end
            if (pop && !pop_acc) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    // Show-ahead: the head entry is presented without a read cycle.
    assign read_data    = mem_q[rd_ptr_q];
    assign empty        = empty_w;
    assign full         = full_w;
    assign almost_empty = (count_q <= AE_LEVEL);
    assign almost_full  = (count_q >= AF_LEVEL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_ff_fifo_any_depth_levels.sv
// ---------------------------------------------------------------------------
// tb_ff_fifo_any_depth_levels
//
// Bench for ff_fifo_any_depth_levels. A default instance (width 8, depth 5)
// runs a table of single-cycle vectors with hand-computed results, a
// push/pop wrap sequence checked against an expected queue, and a mid-cycle
// reset sequence. A second instance (depth 3, almost_empty_level 0) checks
// that almost_empty tracks empty.
// ---------------------------------------------------------------------------
module tb_ff_fifo_any_depth_levels;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main instance (depth 5) ----------------
    logic       clr = 1'b0, push = 1'b0, pop = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic [2:0] count;

    ff_fifo_any_depth_levels u_dut (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop),
        .write_data(wdata), .read_data(rdata), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    // ---------------- small instance (depth 3, ae level 0) ----------------
    logic       s_clr = 1'b0, s_push = 1'b0, s_pop = 1'b0;
    logic [7:0] s_wdata = 8'h00;
    logic [7:0] s_rdata;
    logic       s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
    logic [1:0] s_count;

    ff_fifo_any_depth_levels #(
        .width(8), .depth(3), .almost_empty_level(0)
    ) u_small (
        .clk(clk), .rst(rst), .clr(s_clr), .push(s_push), .pop(s_pop),
        .write_data(s_wdata), .read_data(s_rdata), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic p, input logic q, input logic c, input logic [7:0] d);
        @(negedge clk);
        push = p; pop = q; clr = c; wdata = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0;
    endtask

    task automatic s_step(input logic p, input logic q, input logic [7:0] d);
        @(negedge clk);
        s_push = p; s_pop = q; s_wdata = d;
        @(posedge clk);
        #1;
        s_push = 1'b0; s_pop = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       push, pop, clr;
        logic [7:0] wd;
        logic [2:0] cnt;
        logic [7:0] rd;
        logic       emp, ful, ae, af, ovf, udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic p, input logic q, input logic c, input logic [7:0] d,
                       input logic [2:0] cn, input logic [7:0] r, input logic e,
                       input logic f, input logic ae, input logic af,
                       input logic o, input logic u);
        vec_t v;
        v.push = p; v.pop = q; v.clr = c; v.wd = d; v.cnt = cn; v.rd = r;
        v.emp = e; v.ful = f; v.ae = ae; v.af = af; v.ovf = o; v.udf = u;
        vecs.push_back(v);
    endtask

    initial begin
        //  push pop clr data   cnt  rd     emp ful ae af ovf udf
        // fill 0x11..0x15 then drain in order
        add(1, 0, 0, 8'h11, 1, 8'h11, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 8'h12, 2, 8'h11, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h13, 3, 8'h11, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h14, 4, 8'h11, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 8'h15, 5, 8'h11, 0, 1, 0, 1, 0, 0);
        add(0, 1, 0, 8'h00, 4, 8'h12, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 8'h00, 3, 8'h13, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 2, 8'h14, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 1, 8'h15, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0);
        // full, then push+pop 0xAA, then rejected push 0x77
        add(1, 0, 0, 8'h21, 1, 8'h21, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 8'h22, 2, 8'h21, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h23, 3, 8'h21, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h24, 4, 8'h21, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 8'h25, 5, 8'h21, 0, 1, 0, 1, 0, 0);
        add(1, 1, 0, 8'hAA, 5, 8'h22, 0, 1, 0, 1, 0, 0);
        add(1, 0, 0, 8'h77, 5, 8'h22, 0, 1, 0, 1, 1, 0);
        add(0, 1, 0, 8'h00, 4, 8'h23, 0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 8'h00, 3, 8'h24, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 8'h00, 2, 8'h25, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 8'h00, 1, 8'hAA, 0, 0, 1, 0, 1, 0);
        add(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 1, 0);
        add(0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0);
        // push+pop on empty
        add(1, 1, 0, 8'h5C, 1, 8'h5C, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 8'h00, 1, 8'h5C, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 1);
        // clr with push at count 3
        add(0, 0, 1, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 8'h31, 1, 8'h31, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 8'h32, 2, 8'h31, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h33, 3, 8'h31, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 8'h99, 0, 8'h00, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 8'h44, 1, 8'h44, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 8'h45, 2, 8'h44, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 1, 8'h45, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] next_d;
        logic [1:0] s_exp_cnt;
        logic [7:0] s_exp_head;

        // reset state, checked while rst is held
        #2;
        check("rst count", count, 0);
        check("rst empty", empty, 1);
        check("rst full", full, 0);
        check("rst almost_empty", almost_empty, 1);
        check("rst almost_full", almost_full, 0);
        check("rst overflow", overflow, 0);
        check("rst underflow", underflow, 0);
        @(negedge clk);
        rst = 1'b0;

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].wd);
            check($sformatf("vec%0d count", i), count, vecs[i].cnt);
            check($sformatf("vec%0d empty", i), empty, vecs[i].emp);
            check($sformatf("vec%0d full", i), full, vecs[i].ful);
            check($sformatf("vec%0d almost_empty", i), almost_empty, vecs[i].ae);
            check($sformatf("vec%0d almost_full", i), almost_full, vecs[i].af);
            check($sformatf("vec%0d overflow", i), overflow, vecs[i].ovf);
            check($sformatf("vec%0d underflow", i), underflow, vecs[i].udf);
            if (!vecs[i].emp)
                check($sformatf("vec%0d read_data", i), rdata, vecs[i].rd);
        end

        // pointer wrap: 7 rounds of push 3 / pop 3
        next_d = 8'h80;
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < 3; k++) begin
                step(1, 0, 0, next_d);
                exp_q.push_back(next_d);
                next_d++;
            end
            for (int k = 0; k < 3; k++) begin
                check($sformatf("wrap r%0d k%0d read_data", r, k), rdata, exp_q[0]);
                void'(exp_q.pop_front());
                step(0, 1, 0, 8'h00);
            end
        end
        check("wrap empty", empty, 1);
        check("wrap overflow", overflow, 0);
        check("wrap underflow", underflow, 0);

        // asynchronous reset between edges with 4 words queued
        for (int k = 0; k < 4; k++) step(1, 0, 0, 8'h51 + 8'(k));
        check("pre-rst count", count, 4);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async rst count", count, 0);
        check("async rst empty", empty, 1);
        #1 rst = 1'b0;
        step(1, 0, 0, 8'h66);
        step(1, 0, 0, 8'h67);
        check("post-rst head", rdata, 8'h66);
        check("post-rst count", count, 2);
        step(0, 1, 0, 8'h00);
        check("post-rst second", rdata, 8'h67);
        step(0, 1, 0, 8'h00);

        // depth-3 instance: almost_empty must equal empty throughout
        s_exp_cnt = 2'd0;
        check("small ae at start", s_ae, 1);
        for (int k = 0; k < 4; k++) begin
            s_step(1, 0, 8'hA1 + 8'(k));
            if (s_exp_cnt < 2'd3) s_exp_cnt++;
            check($sformatf("small push%0d count", k), s_count, s_exp_cnt);
            check($sformatf("small push%0d almost_empty", k), s_ae, (s_exp_cnt == 0));
            check($sformatf("small push%0d empty", k), s_empty, (s_exp_cnt == 0));
        end
        check("small overflow", s_ovf, 1);
        s_exp_head = 8'hA1;
        for (int k = 0; k < 4; k++) begin
            if (s_exp_cnt != 0) begin
                check($sformatf("small pop%0d read_data", k), s_rdata, s_exp_head);
                s_exp_head++;
            end
            s_step(0, 1, 8'h00);
            if (s_exp_cnt != 0) s_exp_cnt--;
            check($sformatf("small pop%0d count", k), s_count, s_exp_cnt);
            check($sformatf("small pop%0d almost_empty", k), s_ae, (s_exp_cnt == 0));
            check($sformatf("small pop%0d empty", k), s_empty, (s_exp_cnt == 0));
        end
        check("small underflow", s_udf, 1);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
